spsram_burst_ctrl: RTL and testbench

Burst access controller sitting directly upstream of the 128-bit single-port SRAM wrapper (`f_spsram_*x128`). It accepts burst read/write commands on valid/ready channels and converts them into per-beat SRAM accesses, driving `CEN`, `WEN`, `A` and `D`. It also captures `Q` into a 2-entry read buffer, so downstream backpressure never loses data.

---
 rtl/spsram_ctrl_pkg.sv | 32 +++
 rtl/spsram_rd_fifo.sv | 71 +++++++
 rtl/spsram_burst_ctrl.sv | 152 +++++++++++++++
 tb/tb_spsram_burst_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spsram_ctrl_pkg.sv
// Shared definitions for the single-port SRAM burst controller.
// Contents:
//   - default width constants for address, data and burst-length fields
//   - FSM state encoding shared by the controller
//   - rd_credit_ok(): read-issue credit check against the 2-entry read buffer
package spsram_ctrl_pkg;

    localparam int ADDR_WIDTH_DEF = 15;
    localparam int DATA_WIDTH_DEF = 128;
    localparam int LEN_WIDTH_DEF  = 4;
    localparam int RD_FIFO_DEPTH  = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2
    } state_t;

    // A new read may issue only if every beat already in the buffer or in
    // flight, minus the one leaving this cycle, still leaves a free slot.
    // Written as (count + inflight) < (2 + pop) so nothing can underflow.
    function automatic logic rd_credit_ok(input logic [1:0] count,
                                          input logic       inflight,
                                          input logic       pop);
        logic [2:0] used;
        logic [2:0] limit;
        used  = {1'b0, count} + {2'b00, inflight};
        limit = 3'd2 + {2'b00, pop};
        return (used < limit);
    endfunction

endpackage

// File: rtl/spsram_rd_fifo.sv
// Two-entry {data, last} FIFO that captures SRAM read data so downstream
// backpressure never loses a beat.
// Ports:
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_push, i_data, i_last   write side (one beat per cycle)
//   i_pop                consume the head entry
//   o_valid              FIFO non-empty
//   o_data, o_last       head entry
//   o_count              occupancy 0..2, used by the issuing logic for credit
module spsram_rd_fifo
    import spsram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_last,
    input  logic                  i_pop,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_last,
    output logic [1:0]            o_count
);

    logic [DATA_WIDTH-1:0] r_data [0:RD_FIFO_DEPTH-1];
    logic [1:0]            r_last;
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_count;
    logic                  w_do_push;
    logic                  w_do_pop;

    // When full, a push is only legal alongside a pop: the slot being
    // written is then the one just vacated by the head.
    assign w_do_pop  = i_pop && (r_count != 2'd0);
    assign w_do_push = i_push && ((r_count != 2'd2) || w_do_pop);

    // Storage, pointers and occupancy.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data[0] <= {DATA_WIDTH{1'b0}};
            r_data[1] <= {DATA_WIDTH{1'b0}};
            r_last    <= 2'b00;
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_count   <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_data[r_wr_ptr] <= i_data;
                r_last[r_wr_ptr] <= i_last;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_data[r_rd_ptr];
    assign o_last  = r_last[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/spsram_burst_ctrl.sv
// Burst access controller in front of a single-port SRAM wrapper.
// Converts burst read/write commands into per-beat SRAM accesses and
// buffers read data in a 2-entry FIFO.
// Ports:
//   CLK, RST                         clock, synchronous active-high reset
//   cmd_valid/cmd_ready, cmd_write, cmd_addr, cmd_len   burst command
//   wdata_valid/wdata_ready, wdata, wstrb               write beats
//   wr_done                          one-cycle pulse after the last write beat
//   rdata_valid/rdata_ready, rdata, rdata_last          read beats
//   A, CEN, WEN, D, Q                SRAM pins (CEN/WEN active-low)
module spsram_burst_ctrl
    import spsram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int LEN_WIDTH  = LEN_WIDTH_DEF
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [LEN_WIDTH-1:0]    cmd_len,
    input  logic                    wdata_valid,
    output logic                    wdata_ready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wr_done,
    output logic                    rdata_valid,
    input  logic                    rdata_ready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    rdata_last,
    output logic [ADDR_WIDTH-1:0]   A,
    output logic                    CEN,
    output logic [DATA_WIDTH/8-1:0] WEN,
    output logic [DATA_WIDTH-1:0]   D,
    input  logic [DATA_WIDTH-1:0]   Q
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [LEN_WIDTH-1:0]  LEN_ZERO  = {LEN_WIDTH{1'b0}};
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE   = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_cur_addr;
    logic [LEN_WIDTH-1:0]  r_beats_left;
    logic                  r_inflight;
    logic                  r_inflight_last;
    logic                  r_wr_done;

    logic                  w_run;
    logic                  w_cmd_hs;
    logic                  w_wr_hs;
    logic                  w_pop;
    logic                  w_rd_issue;
    logic                  w_last_beat;
    logic [1:0]            w_fifo_count;

    // Reset gates every handshake and SRAM access combinationally, so the
    // SRAM sees CEN=1 for the whole reset cycle even if a burst was running.
    assign w_run       = ~RST;
    assign cmd_ready   = (r_state == ST_IDLE) && w_run;
    assign wdata_ready = (r_state == ST_WR) && w_run;
    assign w_cmd_hs    = cmd_valid && cmd_ready;
    assign w_wr_hs     = wdata_valid && wdata_ready;
    assign w_pop       = rdata_valid && rdata_ready;
    assign w_last_beat = (r_beats_left == LEN_ZERO);
    assign w_rd_issue  = (r_state == ST_RD) && w_run
                         && rd_credit_ok(w_fifo_count, r_inflight, w_pop);
    assign wr_done     = r_wr_done;

    // SRAM pin drive: same-cycle access for write beats and read issues.
    always_comb begin
        CEN = 1'b1;
        WEN = {STRB_WIDTH{1'b1}};
        A   = r_cur_addr;
        D   = {DATA_WIDTH{1'b0}};
        if (w_wr_hs) begin
            CEN = 1'b0;
            WEN = ~wstrb;
            D   = wdata;
        end else if (w_rd_issue) begin
            CEN = 1'b0;
        end else begin
            CEN = 1'b1;
        end
    end

    // Burst FSM: address/length tracking, read-in-flight flag, wr_done pulse.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state         <= ST_IDLE;
            r_cur_addr      <= {ADDR_WIDTH{1'b0}};
            r_beats_left    <= LEN_ZERO;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_wr_done       <= 1'b0;
        end else begin
            // Q of an issue lands next cycle; remember it and its last flag.
            r_inflight      <= w_rd_issue;
            r_inflight_last <= w_rd_issue && w_last_beat;
            r_wr_done       <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_cmd_hs) begin
                        r_cur_addr   <= cmd_addr;
                        r_beats_left <= cmd_len;
                        r_state      <= cmd_write ? ST_WR : ST_RD;
                    end
                end
                ST_WR: begin
                    if (w_wr_hs) begin
                        r_cur_addr   <= r_cur_addr + ADDR_ONE;
                        r_beats_left <= r_beats_left - LEN_ONE;
                        if (w_last_beat) begin
                            r_state   <= ST_IDLE;
                            r_wr_done <= 1'b1;
                        end
                    end
                end
                ST_RD: begin
                    if (w_rd_issue) begin
                        r_cur_addr   <= r_cur_addr + ADDR_ONE;
                        r_beats_left <= r_beats_left - LEN_ONE;
                        if (w_last_beat) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    spsram_rd_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rd_fifo (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_push  (r_inflight),
        .i_data  (Q),
        .i_last  (r_inflight_last),
        .i_pop   (w_pop),
        .o_valid (rdata_valid),
        .o_data  (rdata),
        .o_last  (rdata_last),
        .o_count (w_fifo_count)
    );

endmodule

// File: tb/tb_spsram_burst_ctrl.sv
// Self-checking bench for spsram_burst_ctrl: SRAM pin model, command-level
// reference model checked every cycle, directed tests plus random bursts.
module tb_spsram_burst_ctrl;

    localparam int AW = 15;
    localparam int DW = 128;
    localparam int LW = 4;
    localparam int SW = DW / 8;
    localparam int NW = 1 << AW;

    logic          CLK, RST;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          wdata_valid, wdata_ready;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          wr_done;
    logic          rdata_valid, rdata_ready;
    logic [DW-1:0] rdata;
    logic          rdata_last;
    logic [AW-1:0] A;
    logic          CEN;
    logic [SW-1:0] WEN;
    logic [DW-1:0] D, Q;

    spsram_burst_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .CLK(CLK), .RST(RST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata), .wstrb(wstrb),
        .wr_done(wr_done),
        .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata), .rdata_last(rdata_last),
        .A(A), .CEN(CEN), .WEN(WEN), .D(D), .Q(Q)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_total = 0;
    int n_pass  = 0;

    task automatic chkw(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    task automatic chki(input string nm, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    endtask

    task automatic chk1(input string nm, input logic got, input logic exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", nm, got, exp);
    endtask

    task automatic timeout_fail(input string nm);
        n_total++;
        $display("FAIL %s: timed out waiting for DUT", nm);
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nd,
                                            input logic [SW-1:0] wen_n);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < SW; b++) if (!wen_n[b]) r[b*8 +: 8] = nd[b*8 +: 8];
        return r;
    endfunction

    // ---------------- SRAM pin model (the wrapper) ----------------
    logic          init_clr;
    logic [DW-1:0] sram [0:NW-1];

    always @(posedge CLK) begin
        if (init_clr) begin
            for (int i = 0; i < NW; i++) sram[i] <= '0;
            Q <= '0;
        end else if (!CEN) begin
            if (WEN == {SW{1'b1}}) Q <= sram[A];
            else sram[A] <= merge(sram[A], D, WEN);
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    typedef struct { logic [DW-1:0] data; logic last; int t; } beat_t;
    typedef struct { logic [AW-1:0] a; logic [SW-1:0] wen; } wr_obs_t;

    logic [DW-1:0] ref_mem [0:NW-1];
    beat_t   beat_q[$];   // issued, not yet consumed beats; t = first visible cycle
    beat_t   obs_rd[$];   // consumed beats as seen on the DUT, t = cycle
    wr_obs_t obs_wr[$];
    int m_mode = 0;       // 0 idle, 1 write burst, 2 read burst
    int m_left = 0;
    logic [AW-1:0] m_addr = '0;
    logic m_wr_done = 1'b0;
    int cyc = 0, acc_cyc = 0, last_wbeat_cyc = 0, wr_done_cyc = 0;
    int n_rd_issue = 0, max_out = 0, max_all = 0;
    logic e_rv, e_pop, e_cen;
    logic [SW-1:0] e_wen;
    logic [DW-1:0] e_d;
    logic [AW-1:0] e_a;

    initial begin
        for (int i = 0; i < NW; i++) ref_mem[i] = '0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                chk1("rst_cen", CEN, 1'b1);
                chki("rst_wen", int'(WEN), 32'hFFFF);
                chk1("rst_cmd_ready", cmd_ready, 1'b0);
                m_mode = 0; m_left = 0; m_addr = '0; m_wr_done = 1'b0;
                beat_q.delete();
            end else begin
                chk1("cmd_ready", cmd_ready, m_mode == 0);
                chk1("wdata_ready", wdata_ready, m_mode == 1);
                chk1("wr_done", wr_done, m_wr_done);
                e_rv = (beat_q.size() > 0) && (beat_q[0].t <= cyc);
                chk1("rdata_valid", rdata_valid, e_rv);
                e_pop = e_rv && rdata_ready;
                if (e_rv) begin
                    chkw("rdata", rdata, beat_q[0].data);
                    chk1("rdata_last", rdata_last, beat_q[0].last);
                end
                if (e_pop) obs_rd.push_back('{rdata, rdata_last, cyc});
                if (wr_done) wr_done_cyc = cyc;
                e_cen = 1'b1; e_wen = '1; e_d = '0; e_a = m_addr; m_wr_done = 1'b0;
                case (m_mode)
                    1: if (wdata_valid) begin
                        e_cen = 1'b0; e_wen = ~wstrb; e_d = wdata;
                        ref_mem[m_addr] = merge(ref_mem[m_addr], wdata, ~wstrb);
                        obs_wr.push_back('{A, WEN});
                        last_wbeat_cyc = cyc;
                        m_addr++; m_left--;
                        if (m_left == 0) begin m_mode = 0; m_wr_done = 1'b1; end
                    end
                    2: if (beat_q.size() - (e_pop ? 1 : 0) < 2) begin
                        e_cen = 1'b0;
                        beat_q.push_back('{ref_mem[m_addr], m_left == 1, cyc + 2});
                        n_rd_issue++;
                        m_addr++; m_left--;
                        if (m_left == 0) m_mode = 0;
                    end
                    default: if (cmd_valid) begin
                        m_addr = cmd_addr; m_left = int'(cmd_len) + 1;
                        m_mode = cmd_write ? 1 : 2; acc_cyc = cyc;
                    end
                endcase
                chki("A", int'(A), int'(e_a));
                chk1("CEN", CEN, e_cen);
                chki("WEN", int'(WEN), int'(e_wen));
                chkw("D", D, e_d);
                if (e_pop) void'(beat_q.pop_front());
                if (beat_q.size() > max_out) max_out = beat_q.size();
                if (beat_q.size() > max_all) max_all = beat_q.size();
            end
            cyc++;
        end
    end

    // ---------------- rdata_ready pattern generator ----------------
    int rr_mode = 0;   // 0 always ready, 1 random, 2 one-on/three-off
    int rr_ph = 0;
    initial begin
        rdata_ready = 1'b1;
        forever begin
            @(posedge CLK); #1;
            rr_ph++;
            case (rr_mode)
                0: rdata_ready = 1'b1;
                1: rdata_ready = 1'($urandom_range(0, 1));
                2: rdata_ready = ((rr_ph % 4) == 0);
                default: rdata_ready = 1'b1;
            endcase
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic do_cmd(input logic w, input logic [AW-1:0] a, input int len);
        int k;
        @(posedge CLK); #1;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = LW'(len);
        k = 0;
        @(negedge CLK);
        while (!cmd_ready && k < 100) begin @(negedge CLK); k++; end
        if (!cmd_ready) timeout_fail("cmd_timeout");
        @(posedge CLK); #1;
        cmd_valid = 1'b0;
    endtask

    // kind 0: random data/strobes, 1: incrementing pattern, 2: fixed fd/fs
    task automatic write_burst(input logic [AW-1:0] a, input int n, input int gap_max,
                               input int kind, input logic [DW-1:0] fd, input logic [SW-1:0] fs);
        int k, g;
        do_cmd(1'b1, a, n - 1);
        for (int i = 0; i < n; i++) begin
            g = $urandom_range(0, gap_max);
            repeat (g) begin wdata_valid = 1'b0; @(posedge CLK); #1; end
            wdata_valid = 1'b1;
            case (kind)
                0: begin wdata = {$urandom, $urandom, $urandom, $urandom}; wstrb = SW'($urandom); end
                1: begin wdata = {4{32'h0100_0000 + 32'(i)}}; wstrb = '1; end
                default: begin wdata = fd; wstrb = fs; end
            endcase
            k = 0;
            @(negedge CLK);
            while (!wdata_ready && k < 100) begin @(negedge CLK); k++; end
            if (!wdata_ready) timeout_fail("wdata_timeout");
            @(posedge CLK); #1;
        end
        wdata_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        do begin @(negedge CLK); #1; k++; end
        while (!(m_mode == 0 && beat_q.size() == 0) && k < 2000);
        if (k >= 2000) timeout_fail("idle_timeout");
    endtask

    task automatic read_burst(input logic [AW-1:0] a, input int n);
        do_cmd(1'b0, a, n - 1);
        wait_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [AW-1:0] exp_a [4];
        logic [AW-1:0] ra;
        int base, k, len;
        RST = 1'b1; init_clr = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wdata_valid = 1'b0; wdata = '0; wstrb = '0;
        repeat (2) @(posedge CLK);
        #1; init_clr = 1'b0;
        @(negedge CLK);
        chk1("reset_cmd_ready", cmd_ready, 1'b0);
        chk1("reset_wdata_ready", wdata_ready, 1'b0);
        chk1("reset_wr_done", wr_done, 1'b0);
        chk1("reset_rdata_valid", rdata_valid, 1'b0);
        chkw("reset_rdata", rdata, '0);
        chk1("reset_rdata_last", rdata_last, 1'b0);
        chki("reset_A", int'(A), 0);
        chkw("reset_D", D, '0);
        @(posedge CLK); #1; RST = 1'b0;
        @(negedge CLK);
        chk1("post_reset_cmd_ready", cmd_ready, 1'b1);

        // single write + readback
        write_burst(15'h0010, 1, 0, 2, 128'h00112233_44556677_8899AABB_CCDDEEFF, 16'hFFFF);
        wait_idle();
        chki("t1_wr_done_latency", wr_done_cyc - last_wbeat_cyc, 1);
        obs_rd.delete();
        read_burst(15'h0010, 1);
        chki("t1_rd_beats", obs_rd.size(), 1);
        if (obs_rd.size() >= 1) begin
            chkw("t1_rdata", obs_rd[0].data, 128'h00112233_44556677_8899AABB_CCDDEEFF);
            chk1("t1_rdata_last", obs_rd[0].last, 1'b1);
            chki("t1_rd_latency", obs_rd[0].t - acc_cyc, 3);
        end

        // byte strobes
        write_burst(15'h0020, 1, 0, 2, {DW{1'b1}}, 16'hFFFF);
        wait_idle();
        obs_wr.delete();
        write_burst(15'h0020, 1, 0, 2, '0, 16'h00F0);
        wait_idle();
        chki("t2_wr_count", obs_wr.size(), 1);
        if (obs_wr.size() >= 1) chki("t2_wen", int'(obs_wr[0].wen), 32'hFF0F);
        obs_rd.delete();
        read_burst(15'h0020, 1);
        if (obs_rd.size() >= 1) chkw("t2_rdata", obs_rd[0].data, 128'hFFFFFFFF_FFFFFFFF_00000000_FFFFFFFF);
        else timeout_fail("t2_no_rdata");

        // streaming 16-beat read
        write_burst(15'h0100, 16, 1, 1, '0, '0);
        wait_idle();
        rr_mode = 0;
        obs_rd.delete();
        read_burst(15'h0100, 16);
        chki("t3_beats", obs_rd.size(), 16);
        if (obs_rd.size() == 16) begin
            chki("t3_span", obs_rd[15].t - obs_rd[0].t, 15);
            for (int i = 0; i < 16; i++) begin
                chkw("t3_data", obs_rd[i].data, {4{32'h0100_0000 + 32'(i)}});
                chk1("t3_last", obs_rd[i].last, i == 15);
            end
        end

        // backpressure 1-on/3-off
        rr_mode = 2; max_out = 0;
        obs_rd.delete();
        read_burst(15'h0100, 8);
        rr_mode = 0;
        chki("t4_max_outstanding", max_out, 2);
        chki("t4_beats", obs_rd.size(), 8);
        if (obs_rd.size() == 8)
            for (int i = 0; i < 8; i++) chkw("t4_data", obs_rd[i].data, {4{32'h0100_0000 + 32'(i)}});

        // wrap-around
        obs_wr.delete();
        write_burst(15'h7FFE, 4, 1, 0, '0, '0);
        wait_idle();
        exp_a[0] = 15'h7FFE; exp_a[1] = 15'h7FFF; exp_a[2] = 15'h0000; exp_a[3] = 15'h0001;
        chki("t5_wr_count", obs_wr.size(), 4);
        if (obs_wr.size() == 4)
            for (int i = 0; i < 4; i++) chki("t5_addr", int'(obs_wr[i].a), int'(exp_a[i]));
        read_burst(15'h7FFE, 4);

        // reset after the 3rd issue of a 16-beat read
        base = n_rd_issue;
        do_cmd(1'b0, 15'h0100, 15);
        k = 0;
        while (n_rd_issue < base + 3 && k < 100) begin @(negedge CLK); #1; k++; end
        if (n_rd_issue < base + 3) timeout_fail("t6_issue_timeout");
        @(posedge CLK); #1; RST = 1'b1;
        @(posedge CLK); #1; RST = 1'b0;
        @(negedge CLK);
        chk1("t6_rdata_valid", rdata_valid, 1'b0);
        chk1("t6_cen", CEN, 1'b1);
        chk1("t6_cmd_ready", cmd_ready, 1'b1);
        obs_rd.delete();
        read_burst(15'h0010, 1);
        if (obs_rd.size() >= 1) chkw("t6_rdata", obs_rd[0].data, 128'h00112233_44556677_8899AABB_CCDDEEFF);
        else timeout_fail("t6_no_rdata");

        // random bursts
        for (int it = 0; it < 30; it++) begin
            ra  = ($urandom_range(0, 3) == 0) ? (15'h7FF0 + AW'($urandom_range(0, 15))) : AW'($urandom);
            len = $urandom_range(1, 16);
            rr_mode = $urandom_range(0, 2);
            if ($urandom_range(0, 1) == 1) begin
                write_burst(ra, len, 2, 0, '0, '0);
                wait_idle();
            end else begin
                read_burst(ra, len);
            end
        end
        rr_mode = 0;
        chk1("max_outstanding_le_2", max_all <= 2, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
